subservient_dbg_arb: RTL and testbench
======================================

// Module: subservient_dbg_arb
// PURPOSE
//  Serial-frame sequencer and round-robin arbiter for a debug-to-Wishbone bridge (dbg_if).
//  Two parallel command requesters (e.g. UART host bridge, JTAG bridge) share one serial debug link.
//  Serialises {id, sel, adr, dat} MSB first, then waits for the target Wishbone ack or a timeout.
// PARAMETERS
//  dbg_aw   1    width of core id field; must be >=1; frame length FL = dbg_aw+68
//  BIT_DIV  1    clocks per serial bit (1..255); o_dbg_valid pulses once per bit
//  TIMEOUT  255  max cycles in WAIT before error (1..65535); 0 = wait forever
// PORTS
//  i_clk         in   1       clock
//  i_rst_n       in   1       asynchronous active-low reset
//  i_req0_valid  in   1       requester 0 command valid
//  o_req0_ready  out  1       requester 0 command accepted this cycle
//  i_req0_id     in   dbg_aw  requester 0 target core id
//  i_req0_sel    in   4       requester 0 byte select
//  i_req0_adr    in   32      requester 0 address
//  i_req0_dat    in   32      requester 0 write data
//  i_req1_*      in   -       requester 1, same as req0 (valid/id/sel/adr/dat)
//  o_req1_ready  out  1       requester 1 command accepted
//  o_dbg_data    out  1       serial frame bit
//  o_dbg_valid   out  1       shift strobe, one cycle per bit
//  i_dbg_ack     in   1       target Wishbone ack, one-cycle pulse
//  o_done        out  1       one-cycle pulse: transaction acked
//  o_err         out  1       one-cycle pulse: transaction timed out
//  o_src         out  1       requester index of the completing transaction, valid with o_done/o_err
//  o_busy        out  1       high in SHIFT or WAIT
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=IDLE, all outputs 0, RR pointer favours req0.
//  States: IDLE -> SHIFT -> WAIT -> IDLE.
//  - IDLE: ready is combinational, raised only for the granted valid requester. Grant rules:
//    - one requester valid: it is granted;
//    - both valid: the requester not granted last wins;
//    - after reset, req0 wins a tie.
//    On handshake (valid & ready) at cycle N, latch {id,sel,adr,dat} into a FL-bit shift register,
//    record src, update RR pointer, and enter SHIFT at N+1.
//    Inputs are sampled only at handshake; later changes are ignored.
//  - SHIFT: o_dbg_data = sreg MSB (id MSB first, dat LSB last).
//    Each bit is held BIT_DIV cycles. o_dbg_valid is high in the last cycle of each bit period.
//    After the last strobe, sreg shifts left by 1. Bit counter runs 0..FL-1.
//    After the FL-th strobe, go to WAIT and clear the timeout counter.
//    With BIT_DIV=1, o_dbg_valid is high for FL consecutive cycles, N+1..N+FL.
//  - WAIT: o_dbg_valid=0, o_dbg_data=0.
//    i_dbg_ack=1 -> o_done pulse, o_src valid, return to IDLE next cycle.
//    The timeout counter increments each cycle. When it reaches TIMEOUT -> o_err pulse, back to IDLE.
//    If ack and expiry coincide, the ack wins: o_done only, never both.
//  - i_dbg_ack outside WAIT is ignored. o_done/o_err are mutually exclusive.
//  - A new command can be accepted in the cycle after o_done/o_err; no other gap is required.
//  - Reset mid-frame aborts immediately. The slave shift counter must be reset by the same system reset.
//  - Counters: bit counter 7b, divider 8b, timeout 16b, no wrap in normal use.
// TESTING
//  1 Single write: req0 {id=1, sel=F, adr=0x40000000, dat=0xDEADBEEF}, BIT_DIV=1.
//    -> ready at N; 69 valid strobes at N+1..N+69; bits = 1,1111,adr,dat MSB first.
//    -> ack at N+75 gives o_done=1, o_src=0 at N+75.
//  2 Contention: both valid every cycle, acks 3 cycles after each frame.
//    -> grants alternate 0,1,0,1; each frame content matches its source.
//  3 Timeout: TIMEOUT=10, no ack.
//    -> o_err pulses exactly once at cycle 10 of WAIT; o_done stays 0; IDLE on the next cycle.
//  4 BIT_DIV=4: each o_dbg_data bit held 4 cycles; o_dbg_valid high 1 of 4 cycles; 69 strobes total.
//  5 Async reset at bit 30 of SHIFT -> all outputs 0 immediately; next req0 after release wins the grant.
//  6 Ack during SHIFT, then ack coinciding with timeout expiry.
//    -> early ack ignored (no o_done); coincident case gives o_done=1, o_err=0.

Source files
------------

// File: rtl/subservient_dbg_arb_if.sv
// Bundle of requester, serial-link and completion signals for subservient_dbg_arb.
// Ports (slave = arbiter side):
//   i_req{0,1}_valid/id/sel/adr/dat  command from requester 0/1
//   o_req{0,1}_ready                 command accepted this cycle
//   o_dbg_data/o_dbg_valid           serial frame bit and per-bit strobe
//   i_dbg_ack                        target Wishbone ack pulse
//   o_done/o_err/o_src/o_busy        completion status
interface subservient_dbg_arb_if #(
    parameter int unsigned dbg_aw = 1
);
    logic              i_req0_valid;
    logic              o_req0_ready;
    logic [dbg_aw-1:0] i_req0_id;
    logic [3:0]        i_req0_sel;
    logic [31:0]       i_req0_adr;
    logic [31:0]       i_req0_dat;

    logic              i_req1_valid;
    logic              o_req1_ready;
    logic [dbg_aw-1:0] i_req1_id;
    logic [3:0]        i_req1_sel;
    logic [31:0]       i_req1_adr;
    logic [31:0]       i_req1_dat;

    logic              o_dbg_data;
    logic              o_dbg_valid;
    logic              i_dbg_ack;
    logic              o_done;
    logic              o_err;
    logic              o_src;
    logic              o_busy;

    modport slave (
        input  i_req0_valid, i_req0_id, i_req0_sel, i_req0_adr, i_req0_dat,
        input  i_req1_valid, i_req1_id, i_req1_sel, i_req1_adr, i_req1_dat,
        input  i_dbg_ack,
        output o_req0_ready, o_req1_ready,
        output o_dbg_data, o_dbg_valid,
        output o_done, o_err, o_src, o_busy
    );

    modport master (
        output i_req0_valid, i_req0_id, i_req0_sel, i_req0_adr, i_req0_dat,
        output i_req1_valid, i_req1_id, i_req1_sel, i_req1_adr, i_req1_dat,
        output i_dbg_ack,
        input  o_req0_ready, o_req1_ready,
        input  o_dbg_data, o_dbg_valid,
        input  o_done, o_err, o_src, o_busy
    );
endinterface

// File: rtl/subservient_dbg_arb.sv
// Round-robin arbiter and serial-frame sequencer for a debug-to-Wishbone bridge.
// Two requesters share one serial link; the granted command {id,sel,adr,dat} is
// shifted out MSB first, then the sequencer waits for the target ack or a timeout.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   bus      subservient_dbg_arb_if.slave (requests, serial link, status)
module subservient_dbg_arb #(
    parameter int unsigned dbg_aw  = 1,
    parameter int unsigned BIT_DIV = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    subservient_dbg_arb_if.slave  bus
);
    localparam int unsigned FL       = dbg_aw + 68;
    localparam logic [6:0]  BIT_LAST = 7'(FL - 1);
    localparam logic [7:0]  DIV_LAST = 8'(BIT_DIV - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic        TMO_EN   = (TIMEOUT != 0);
    localparam logic        DIV_ONE  = (BIT_DIV == 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state;
    logic [FL-2:0] sreg;      // frame bits still to send after the one on the line
    logic [6:0]    bit_cnt;
    logic [7:0]    div_cnt;
    logic [15:0]   tmo_cnt;
    logic          last_src;  // requester granted most recently; reset value favours req0
    logic          src;
    logic          dbg_data;
    logic          dbg_valid;
    logic          busy;

    logic          grant;
    logic          idle;
    logic          ready0;
    logic          ready1;
    logic          handshake;
    logic          ack;
    logic          expire;
    logic [FL-1:0] frame;

    // Grant selection: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant = 1'b0;
        if (bus.i_req0_valid && bus.i_req1_valid) begin
            grant = ~last_src;
        end else if (bus.i_req1_valid) begin
            grant = 1'b1;
        end
    end

    assign idle      = (state == IDLE) && i_rst_n;
    assign ready0    = idle && bus.i_req0_valid && !grant;
    assign ready1    = idle && bus.i_req1_valid && grant;
    assign handshake = ready0 || ready1;
    assign frame     = grant ? {bus.i_req1_id, bus.i_req1_sel, bus.i_req1_adr, bus.i_req1_dat}
                             : {bus.i_req0_id, bus.i_req0_sel, bus.i_req0_adr, bus.i_req0_dat};

    // Completion is reported in the same cycle as the ack; ack beats a coincident expiry.
    assign ack    = (state == WAIT) && bus.i_dbg_ack;
    assign expire = (state == WAIT) && TMO_EN && (tmo_cnt == TMO_LAST) && !bus.i_dbg_ack;

    // Sequencer: latch on handshake, shift one bit per BIT_DIV cycles, then wait.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            sreg      <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            tmo_cnt   <= '0;
            last_src  <= 1'b1;
            src       <= 1'b0;
            dbg_data  <= 1'b0;
            dbg_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        state     <= SHIFT;
                        sreg      <= frame[FL-2:0];
                        dbg_data  <= frame[FL-1];
                        dbg_valid <= DIV_ONE;
                        src       <= grant;
                        last_src  <= grant;
                        bit_cnt   <= '0;
                        div_cnt   <= '0;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state     <= WAIT;
                            tmo_cnt   <= '0;
                            dbg_data  <= 1'b0;
                            dbg_valid <= 1'b0;
                        end else begin
                            bit_cnt   <= bit_cnt + 7'd1;
                            dbg_data  <= sreg[FL-2];
                            sreg      <= {sreg[FL-3:0], 1'b0};
                            dbg_valid <= DIV_ONE;
                        end
                    end else begin
                        div_cnt   <= div_cnt + 8'd1;
                        dbg_valid <= ((div_cnt + 8'd1) == DIV_LAST);
                    end
                end
                WAIT: begin
                    if (ack || expire) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_req0_ready = ready0;
    assign bus.o_req1_ready = ready1;
    assign bus.o_dbg_data   = dbg_data;
    assign bus.o_dbg_valid  = dbg_valid;
    assign bus.o_done       = ack;
    assign bus.o_err        = expire;
    assign bus.o_src        = src;
    assign bus.o_busy       = busy;
endmodule

// File: tb/tb_subservient_dbg_arb.sv
// Directed bench for subservient_dbg_arb: instance A (BIT_DIV=1, TIMEOUT=10),
// instance B (BIT_DIV=4, TIMEOUT=255).
module tb_subservient_dbg_arb;
    localparam int unsigned AW = 1;
    localparam int unsigned FL = AW + 68;
    localparam int R0 = 7, R1 = 6, DV = 5, DD = 4, DN = 3, ER = 2, SR = 1, BZ = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    subservient_dbg_arb_if #(.dbg_aw(AW)) bus_a ();
    subservient_dbg_arb_if #(.dbg_aw(AW)) bus_b ();

    subservient_dbg_arb #(.dbg_aw(AW), .BIT_DIV(1), .TIMEOUT(10)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a.slave)
    );
    subservient_dbg_arb #(.dbg_aw(AW), .BIT_DIV(4), .TIMEOUT(255)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b.slave)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FL-1:0] mk(input logic id, input logic [3:0] s,
                                          input logic [31:0] a, input logic [31:0] d);
        return {id, s, a, d};
    endfunction

    function automatic logic [7:0] outs(input bit sel);
        if (sel)
            return {bus_b.o_req0_ready, bus_b.o_req1_ready, bus_b.o_dbg_valid, bus_b.o_dbg_data,
                    bus_b.o_done, bus_b.o_err, bus_b.o_src, bus_b.o_busy};
        return {bus_a.o_req0_ready, bus_a.o_req1_ready, bus_a.o_dbg_valid, bus_a.o_dbg_data,
                bus_a.o_done, bus_a.o_err, bus_a.o_src, bus_a.o_busy};
    endfunction

    task automatic set_req(input bit sel, input bit r, input bit v, input logic id,
                           input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        if (!sel && !r) begin
            bus_a.i_req0_valid = v; bus_a.i_req0_id = id; bus_a.i_req0_sel = s;
            bus_a.i_req0_adr = a; bus_a.i_req0_dat = d;
        end else if (!sel) begin
            bus_a.i_req1_valid = v; bus_a.i_req1_id = id; bus_a.i_req1_sel = s;
            bus_a.i_req1_adr = a; bus_a.i_req1_dat = d;
        end else if (!r) begin
            bus_b.i_req0_valid = v; bus_b.i_req0_id = id; bus_b.i_req0_sel = s;
            bus_b.i_req0_adr = a; bus_b.i_req0_dat = d;
        end else begin
            bus_b.i_req1_valid = v; bus_b.i_req1_id = id; bus_b.i_req1_sel = s;
            bus_b.i_req1_adr = a; bus_b.i_req1_dat = d;
        end
    endtask

    task automatic set_ack(input bit sel, input bit v);
        if (sel) bus_b.i_dbg_ack = v;
        else     bus_a.i_dbg_ack = v;
    endtask

    task automatic chk_grant(input bit sel, input bit exp_r, input string tag);
        logic [7:0] o;
        o = outs(sel);
        check({tag, "_ready0"}, 128'(o[R0]), 128'(!exp_r));
        check({tag, "_ready1"}, 128'(o[R1]), 128'(exp_r));
    endtask

    // Watches a frame starting the cycle after the handshake; optionally drops and
    // scrambles the requests, and optionally pulses ack at cycle ack_at.
    task automatic capture(input bit sel, input int div, input bit clr, input int ack_at,
                           output logic [FL-1:0] fr, output int nst, output int first,
                           output int last, output int bad, output int ndone);
        logic [7:0] o;
        logic pd;
        logic ps;
        fr = '0; nst = 0; first = 0; last = 0; bad = 0; ndone = 0; pd = 1'b0; ps = 1'b1;
        for (int c = 1; c <= int'(FL) * div + 20 && nst < int'(FL); c++) begin
            @(negedge clk);
            set_ack(sel, c == ack_at);
            #1;
            o = outs(sel);
            if (c == 1 && clr) begin
                set_req(sel, 1'b0, 1'b0, 1'b0, 4'h0, 32'hFFFF_FFFF, 32'h0000_0000);
                set_req(sel, 1'b1, 1'b0, 1'b0, 4'h0, 32'hFFFF_FFFF, 32'h0000_0000);
            end
            if (o[DN] || o[ER]) ndone++;
            if (!ps && o[DD] !== pd) bad++;
            if (o[DV]) begin
                nst++;
                fr = {fr[FL-2:0], o[DD]};
                if (first == 0) first = c;
                last = c;
                if (c % div != 0) bad++;
            end
            pd = o[DD];
            ps = o[DV];
        end
        set_ack(sel, 1'b0);
    endtask

    initial begin
        logic [7:0]    o;
        logic [FL-1:0] fr;
        logic [FL-1:0] f0;
        logic [FL-1:0] f1;
        int nst, first, last, bad, nd, errs, err_at, wbad;

        set_req(0, 0, 0, 0, 4'h0, 32'h0, 32'h0); set_req(0, 1, 0, 0, 4'h0, 32'h0, 32'h0);
        set_req(1, 0, 0, 0, 4'h0, 32'h0, 32'h0); set_req(1, 1, 0, 0, 4'h0, 32'h0, 32'h0);
        set_ack(0, 0); set_ack(1, 0);
        repeat (2) @(negedge clk);
        #1;
        check("reset_a", 128'(outs(0)), 128'(0));
        check("reset_b", 128'(outs(1)), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single write from req0, ack at N+75
        @(negedge clk);
        set_req(0, 0, 1, 1'b1, 4'hF, 32'h4000_0000, 32'hDEAD_BEEF);
        #1;
        chk_grant(0, 0, "t1");
        capture(0, 1, 1, 0, fr, nst, first, last, bad, nd);
        check("t1_frame", 128'(fr), 128'(mk(1'b1, 4'hF, 32'h4000_0000, 32'hDEAD_BEEF)));
        check("t1_strobes", 128'(nst), 128'(69));
        check("t1_first", 128'(first), 128'(1));
        check("t1_last", 128'(last), 128'(69));
        check("t1_done_in_shift", 128'(nd), 128'(0));
        wbad = 0;
        for (int j = 70; j <= 76; j++) begin
            @(negedge clk);
            set_ack(0, j == 75);
            #1;
            o = outs(0);
            if (j < 75 && (o[DN] || o[ER] || o[DV] || o[DD])) wbad++;
            if (j == 75) begin
                check("t1_done", 128'(o[DN]), 128'(1));
                check("t1_err", 128'(o[ER]), 128'(0));
                check("t1_src", 128'(o[SR]), 128'(0));
            end
            if (j == 76) check("t1_idle", 128'(o[BZ] | o[DN]), 128'(0));
        end
        check("t1_wait_quiet", 128'(wbad), 128'(0));

        // Timeout with no ack, using req1
        @(negedge clk);
        set_ack(0, 0);
        set_req(0, 1, 1, 1'b0, 4'h5, 32'hA5A5_0000, 32'h0000_5A5A);
        #1;
        chk_grant(0, 1, "t3");
        capture(0, 1, 1, 0, fr, nst, first, last, bad, nd);
        check("t3_frame", 128'(fr), 128'(mk(1'b0, 4'h5, 32'hA5A5_0000, 32'h0000_5A5A)));
        errs = 0; err_at = 0; nd = 0;
        for (int j = 1; j <= 11; j++) begin
            @(negedge clk);
            #1;
            o = outs(0);
            if (o[ER]) begin
                errs++;
                if (err_at == 0) err_at = j;
            end
            if (o[DN]) nd++;
            if (j == 10) check("t3_src", 128'(o[SR]), 128'(1));
            if (j == 11) check("t3_idle", 128'(o[BZ]), 128'(0));
        end
        check("t3_err_count", 128'(errs), 128'(1));
        check("t3_err_cycle", 128'(err_at), 128'(10));
        check("t3_no_done", 128'(nd), 128'(0));

        // Contention: both valid continuously, grants alternate starting with req0
        f0 = mk(1'b1, 4'h3, 32'h1000_0004, 32'h0123_4567);
        f1 = mk(1'b0, 4'hC, 32'h2000_0008, 32'h89AB_CDEF);
        @(negedge clk);
        set_req(0, 0, 1, 1'b1, 4'h3, 32'h1000_0004, 32'h0123_4567);
        set_req(0, 1, 1, 1'b0, 4'hC, 32'h2000_0008, 32'h89AB_CDEF);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                set_ack(0, 0);
                #1;
            end
            chk_grant(0, 1'(k % 2), $sformatf("t2_g%0d", k));
            capture(0, 1, 0, 0, fr, nst, first, last, bad, nd);
            check($sformatf("t2_frame%0d", k), 128'(fr), 128'((k % 2) ? f1 : f0));
            repeat (2) @(negedge clk);
            @(negedge clk);
            set_ack(0, 1);
            #1;
            o = outs(0);
            check($sformatf("t2_done%0d", k), 128'(o[DN]), 128'(1));
            check($sformatf("t2_src%0d", k), 128'(o[SR]), 128'(k % 2));
        end
        @(negedge clk);
        set_ack(0, 0);
        set_req(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_req(0, 1, 0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        check("t2_idle", 128'(outs(0) & 8'hC1), 128'(0));

        // Ack during SHIFT ignored, then ack coinciding with timeout expiry
        @(negedge clk);
        set_req(0, 0, 1, 1'b0, 4'h1, 32'h0000_0010, 32'h0000_0020);
        #1;
        chk_grant(0, 0, "t6");
        capture(0, 1, 1, 20, fr, nst, first, last, bad, nd);
        check("t6_early_ack", 128'(nd), 128'(0));
        check("t6_strobes", 128'(nst), 128'(69));
        wbad = 0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            set_ack(0, j == 10);
            #1;
            o = outs(0);
            if (j < 10 && (o[DN] || o[ER])) wbad++;
            if (j == 10) begin
                check("t6_done", 128'(o[DN]), 128'(1));
                check("t6_err", 128'(o[ER]), 128'(0));
            end
        end
        check("t6_wait_quiet", 128'(wbad), 128'(0));
        @(negedge clk);
        set_ack(0, 0);
        #1;
        check("t6_idle", 128'(outs(0) & 8'h01), 128'(0));

        // BIT_DIV=4 on instance B from req1
        @(negedge clk);
        set_req(1, 1, 1, 1'b1, 4'h9, 32'h1234_5678, 32'h9ABC_DEF0);
        #1;
        chk_grant(1, 1, "t4");
        capture(1, 4, 1, 0, fr, nst, first, last, bad, nd);
        check("t4_frame", 128'(fr), 128'(mk(1'b1, 4'h9, 32'h1234_5678, 32'h9ABC_DEF0)));
        check("t4_strobes", 128'(nst), 128'(69));
        check("t4_first", 128'(first), 128'(4));
        check("t4_last", 128'(last), 128'(276));
        check("t4_hold", 128'(bad), 128'(0));
        @(negedge clk);
        set_ack(1, 1);
        #1;
        o = outs(1);
        check("t4_done", 128'(o[DN]), 128'(1));
        check("t4_src", 128'(o[SR]), 128'(1));
        @(negedge clk);
        set_ack(1, 0);
        #1;
        check("t4_idle", 128'(outs(1) & 8'h01), 128'(0));

        // Async reset at bit 30 of a req0 frame; a tie afterwards must go to req0
        @(negedge clk);
        set_req(0, 0, 1, 1'b1, 4'h7, 32'h0000_0000, 32'h0000_0001);
        #1;
        chk_grant(0, 0, "t5");
        for (int j = 1; j <= 31; j++) begin
            @(negedge clk);
            if (j == 1) set_req(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
            #1;
        end
        check("t5_mid_valid", 128'(outs(0) & 8'h21), 128'(8'h21));
        #1 rst_n = 1'b0;
        #1;
        check("t5_reset_outs", 128'(outs(0)), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_req(0, 0, 1, 1'b0, 4'h2, 32'h0000_0100, 32'h0000_0200);
        set_req(0, 1, 1, 1'b1, 4'h4, 32'h0000_0300, 32'h0000_0400);
        #1;
        chk_grant(0, 0, "t5_post");
        capture(0, 1, 1, 0, fr, nst, first, last, bad, nd);
        check("t5_frame", 128'(fr), 128'(mk(1'b0, 4'h2, 32'h0000_0100, 32'h0000_0200)));
        @(negedge clk);
        set_ack(0, 1);
        #1;
        check("t5_done", 128'(outs(0) & 8'h0A), 128'(8'h08));
        @(negedge clk);
        set_ack(0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
